uart_tx_fsmd: RTL and testbench

UART transmitter FSMD that serialises one parallel word per frame onto the `Tx` line: start bit, data bits LSB first, optional parity bit, one stop bit. It is the transmit end of the link whose receive end is the team's UART Rx FSMD. It uses the same clock, in which one bit period equals `no_of_samples` clocks, and the same parity and frame parameters, so a Tx/Rx pair with matching parameters loops back error-free. Host logic hands it words through a valid/ready handshake.

---
 rtl/uart_tx_fsmd.sv | 153 +++++++++++++++
 tb/tb_uart_tx_fsmd.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsmd.sv
// ---------------------------------------------------------------------------
// uart_tx_fsmd
//
// UART transmitter (FSM + datapath). Serialises one parallel word per frame:
// start bit (0), data bits LSB first, optional parity bit, one stop bit (1).
// One bit period lasts no_of_samples clocks, matching the companion UART Rx
// FSMD so that a Tx/Rx pair built with the same parameters loops back cleanly.
//
// Parameters
//   parity_on           : 1 inserts a parity bit after the data bits
//   data_size           : data bits per frame (1..8)
//   even_parity         : 1 sends ^data, 0 sends ~^data
//   no_of_samples       : clocks per bit period (>= 2)
//   sampling_cntr_width : width of the in-bit counter (holds no_of_samples-1)
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   data_in    : word to send, captured on accept
//   data_valid : host offers data_in
//   ready      : high exactly while idle (combinational)
//   Tx         : serial line, registered, idles high
//   frame_done : registered one-clock pulse after each stop bit
// ---------------------------------------------------------------------------
module uart_tx_fsmd #(
    parameter int parity_on           = 1,
    parameter int data_size           = 8,
    parameter int even_parity         = 1,
    parameter int no_of_samples       = 16,
    parameter int sampling_cntr_width = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [data_size-1:0] data_in,
    input  logic                 data_valid,
    output logic                 ready,
    output logic                 Tx,
    output logic                 frame_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [sampling_cntr_width-1:0] SAMP_MAX =
        sampling_cntr_width'(no_of_samples - 1);
    localparam logic [2:0] LAST_BIT = 3'(data_size - 1);

    state_t                         state_reg, state_next;
    logic [sampling_cntr_width-1:0] samp_cnt_reg, samp_cnt_next;
    logic [2:0]                     bit_cnt_reg, bit_cnt_next;
    logic [data_size-1:0]           shift_reg, shift_next;
    logic                           parity_reg, parity_next;
    logic                           tx_reg, tx_next;
    logic                           frame_done_reg, frame_done_next;
    logic                           accept;
    logic                           bit_end;

    // ready is a pure function of the current state; keeping it outside the
    // output process avoids a combinational path back into state_next.
    assign ready   = (state_reg == IDLE);
    assign accept  = data_valid && ready;
    assign bit_end = (samp_cnt_reg == SAMP_MAX);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)  state_next = START;
            START:   if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end && (bit_cnt_reg == LAST_BIT)) begin
                    state_next = (parity_on != 0) ? PARITY : STOP;
                end
            end
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        samp_cnt_next = samp_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        if (state_reg == IDLE) begin
            samp_cnt_next = '0;
            if (accept) begin
                shift_next   = data_in;
                bit_cnt_next = '0;
                parity_next  = (even_parity != 0) ? (^data_in) : ~(^data_in);
            end
        end else begin
            samp_cnt_next = bit_end ? '0 : samp_cnt_reg + 1'b1;
            if ((state_reg == DATA) && bit_end) begin
                shift_next   = shift_reg >> 1;
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end
        end
    end

    // ---------------- output logic ----------------
    // Tx is decoded from the *next* state and datapath so the registered line
    // changes on the same edge that the state does (start bit appears on the
    // accept edge, not one clock later).
    always_comb begin
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
        frame_done_next = (state_reg == STOP) && bit_end;
    end

    // ---------------- datapath and output registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            tx_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            samp_cnt_reg   <= samp_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            tx_reg         <= tx_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign Tx         = tx_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_uart_tx_fsmd.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fsmd
//
// Directed bench for uart_tx_fsmd. Three instances share data_in and reset:
//   s=0 : defaults (even parity, parity on)
//   s=1 : odd parity
//   s=2 : no parity bit
// Frames are captured bit by bit (Tx sampled every clock on the falling
// edge) and compared against hand-computed 11-bit / 10-bit patterns laid out
// as {stop, parity, data[7:0], start}.
// ---------------------------------------------------------------------------
module tb_uart_tx_fsmd;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       dv0, dv1, dv2;
    logic       rdy0, rdy1, rdy2;
    logic       tx0, tx1, tx2;
    logic       fd0, fd1, fd2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fsmd dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv0),
        .ready(rdy0), .Tx(tx0), .frame_done(fd0)
    );

    uart_tx_fsmd #(.even_parity(0)) dut_odd (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv1),
        .ready(rdy1), .Tx(tx1), .frame_done(fd1)
    );

    uart_tx_fsmd #(.parity_on(0)) dut_np (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv2),
        .ready(rdy2), .Tx(tx2), .frame_done(fd2)
    );

    function automatic logic get_tx(input int s);
        case (s)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_rdy(input int s);
        case (s)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic get_fd(input int s);
        case (s)
            0:       return fd0;
            1:       return fd1;
            default: return fd2;
        endcase
    endfunction

    task automatic set_dv(input int s, input logic v);
        case (s)
            0:       dv0 = v;
            1:       dv1 = v;
            default: dv2 = v;
        endcase
    endtask

    // Sends one word on instance s and records the frame. j counts falling
    // edges after the accept edge, so j is clock k+j. Optionally pokes
    // data_valid/data_in mid-frame to exercise the busy path.
    task automatic run_frame(input int s, input logic [7:0] d, input int nbits,
                             input bit mid_pulse,
                             output logic [10:0] bits, output bit stable,
                             output int done_at, output int pulses,
                             output int rdy_at, output bit tail_high,
                             output bit accepted);
        int waitc;
        int b;
        bits      = '1;
        stable    = 1'b1;
        done_at   = -1;
        pulses    = 0;
        rdy_at    = -1;
        tail_high = 1'b1;
        accepted  = 1'b0;
        @(negedge clk);
        data_in = d;
        set_dv(s, 1'b1);
        waitc = 0;
        while (!get_rdy(s) && waitc < 400) begin
            @(negedge clk);
            waitc++;
        end
        if (!get_rdy(s)) begin
            set_dv(s, 1'b0);
            return;
        end
        accepted = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= nbits * 16 + 20; j++) begin
            @(negedge clk);
            if (j == 1) begin
                set_dv(s, 1'b0);
                data_in = ~d;
            end
            if (mid_pulse && j == 40) begin
                data_in = 8'hFF;
                set_dv(s, 1'b1);
            end
            if (mid_pulse && j == 41) set_dv(s, 1'b0);
            if (j <= nbits * 16) begin
                b = (j - 1) / 16;
                if ((j - 1) % 16 == 0) bits[b] = get_tx(s);
                else if (get_tx(s) !== bits[b]) stable = 1'b0;
            end else if (get_tx(s) !== 1'b1) begin
                tail_high = 1'b0;
            end
            if (get_fd(s) === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = j;
            end
            if (get_rdy(s) === 1'b1 && rdy_at < 0) rdy_at = j;
        end
    endtask

    task automatic test_reset;
        int bad;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (tx0 !== 1'b1) begin
            errors++; $display("FAIL reset_tx: got %b expected 1", tx0);
        end
        checks++;
        if (rdy0 !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", rdy0);
        end
        checks++;
        if (fd0 !== 1'b0) begin
            errors++; $display("FAIL reset_frame_done: got %b expected 0", fd0);
        end
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || rdy0 !== 1'b1 || fd0 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL idle_after_reset: %0d bad clocks, expected 0", bad);
        end
        $display("test_reset done");
    endtask

    task automatic test_a5;
        logic [10:0] bits;
        bit stable, tail, acc;
        int done_at, pulses, rdy_at;
        run_frame(0, 8'hA5, 11, 1'b0, bits, stable, done_at, pulses, rdy_at, tail, acc);
        checks++;
        if (!acc) begin
            errors++; $display("FAIL a5_accept: got no accept, expected accept");
        end
        checks++;
        if (bits !== 11'b10101001010) begin
            errors++; $display("FAIL a5_bits: got %b expected %b", bits, 11'b10101001010);
        end
        checks++;
        if (!stable) begin
            errors++; $display("FAIL a5_bit_hold: Tx changed inside a bit period, expected 16-clock bits");
        end
        checks++;
        if (done_at != 177) begin
            errors++; $display("FAIL a5_frame_done_time: got clock %0d expected 177", done_at);
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL a5_frame_done_width: got %0d clocks expected 1", pulses);
        end
        checks++;
        if (rdy_at != 177) begin
            errors++; $display("FAIL a5_ready_return: got clock %0d expected 177", rdy_at);
        end
        $display("test_a5: bits=%b done_at=%0d ready_at=%0d", bits, done_at, rdy_at);
    endtask

    task automatic test_parity;
        logic [10:0] bits;
        bit stable, tail, acc;
        int done_at, pulses, rdy_at;
        run_frame(0, 8'h01, 11, 1'b0, bits, stable, done_at, pulses, rdy_at, tail, acc);
        checks++;
        if (bits !== 11'b11000000010) begin
            errors++; $display("FAIL even_parity_01: got %b expected %b", bits, 11'b11000000010);
        end
        $display("test_parity even: bits=%b", bits);
        run_frame(1, 8'h01, 11, 1'b0, bits, stable, done_at, pulses, rdy_at, tail, acc);
        checks++;
        if (bits !== 11'b10000000010) begin
            errors++; $display("FAIL odd_parity_01: got %b expected %b", bits, 11'b10000000010);
        end
        $display("test_parity odd: bits=%b", bits);
        run_frame(2, 8'h01, 10, 1'b0, bits, stable, done_at, pulses, rdy_at, tail, acc);
        checks++;
        if (bits[9:0] !== 10'b1000000010) begin
            errors++; $display("FAIL no_parity_bits: got %b expected %b", bits[9:0], 10'b1000000010);
        end
        checks++;
        if (done_at != 161) begin
            errors++; $display("FAIL no_parity_length: frame_done at clock %0d expected 161", done_at);
        end
        checks++;
        if (!stable || !tail) begin
            errors++; $display("FAIL no_parity_shape: stable=%0d tail=%0d expected 1 1", stable, tail);
        end
        $display("test_parity none: bits=%b done_at=%0d", bits[9:0], done_at);
    endtask

    task automatic test_back_to_back;
        logic       tx_s [0:511];
        logic [10:0] dec_a, dec_b;
        int acc_a, acc_b, nacc;
        acc_a = -1;
        acc_b = -1;
        nacc  = 0;
        dec_a = '0;
        dec_b = '0;
        @(negedge clk);
        data_in = 8'h3C;
        dv0 = 1'b1;
        for (int c = 0; c < 500; c++) begin
            tx_s[c] = tx0;
            if (nacc == 1 && c == acc_a + 1) data_in = 8'hC3;
            if (nacc == 2 && c == acc_b + 1) dv0 = 1'b0;
            if (dv0 && rdy0) begin
                if (nacc == 0) acc_a = c;
                else if (nacc == 1) acc_b = c;
                nacc++;
            end
            @(negedge clk);
        end
        dv0 = 1'b0;
        checks++;
        if (nacc != 2) begin
            errors++; $display("FAIL b2b_accept_count: got %0d expected 2", nacc);
        end
        checks++;
        if (acc_b - acc_a != 177) begin
            errors++; $display("FAIL b2b_spacing: got %0d clocks expected 177", acc_b - acc_a);
        end
        if (acc_a >= 0 && acc_b >= 0 && acc_b <= 330) begin
            for (int b = 0; b < 11; b++) begin
                dec_a[b] = tx_s[acc_a + 9 + 16 * b];
                dec_b[b] = tx_s[acc_b + 9 + 16 * b];
            end
        end
        checks++;
        if (dec_a !== 11'b10001111000) begin
            errors++; $display("FAIL b2b_frame_3c: got %b expected %b", dec_a, 11'b10001111000);
        end
        checks++;
        if (dec_b !== 11'b10110000110) begin
            errors++; $display("FAIL b2b_frame_c3: got %b expected %b", dec_b, 11'b10110000110);
        end
        $display("test_back_to_back: spacing=%0d f1=%b f2=%b", acc_b - acc_a, dec_a, dec_b);
    endtask

    task automatic test_busy;
        logic [10:0] bits;
        bit stable, tail, acc;
        int done_at, pulses, rdy_at;
        run_frame(0, 8'h96, 11, 1'b1, bits, stable, done_at, pulses, rdy_at, tail, acc);
        checks++;
        if (bits !== 11'b10100101100 || !stable) begin
            errors++; $display("FAIL busy_frame: got %b stable=%0d expected %b stable=1",
                               bits, stable, 11'b10100101100);
        end
        checks++;
        if (!tail || pulses != 1) begin
            errors++; $display("FAIL busy_no_extra: tail_high=%0d pulses=%0d expected 1 1", tail, pulses);
        end
        $display("test_busy: bits=%b pulses=%0d", bits, pulses);
    endtask

    task automatic test_reset_midframe;
        logic [10:0] bits;
        bit stable, tail, acc;
        int done_at, pulses, rdy_at, bad, fdc;
        @(negedge clk);
        data_in = 8'hA5;
        dv0 = 1'b1;
        checks++;
        if (rdy0 !== 1'b1) begin
            errors++; $display("FAIL midrst_pre_ready: got %b expected 1", rdy0);
        end
        @(posedge clk);
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            if (j == 1) dv0 = 1'b0;
        end
        // clock k+70 lies in data bit 3; bit 3 of 0xA5 is 0
        checks++;
        if (tx0 !== 1'b0) begin
            errors++; $display("FAIL midrst_bit3: got %b expected 0", tx0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (tx0 !== 1'b1 || rdy0 !== 1'b1 || fd0 !== 1'b0) begin
            errors++; $display("FAIL midrst_immediate: tx=%b ready=%b fd=%b expected 1 1 0", tx0, rdy0, fd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        fdc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || rdy0 !== 1'b1) bad++;
            if (fd0 === 1'b1) fdc++;
        end
        checks++;
        if (bad != 0 || fdc != 0) begin
            errors++; $display("FAIL midrst_no_resume: bad=%0d frame_done=%0d expected 0 0", bad, fdc);
        end
        run_frame(0, 8'h3C, 11, 1'b0, bits, stable, done_at, pulses, rdy_at, tail, acc);
        checks++;
        if (bits !== 11'b10001111000 || done_at != 177) begin
            errors++; $display("FAIL midrst_new_frame: got %b done=%0d expected %b done=177",
                               bits, done_at, 11'b10001111000);
        end
        $display("test_reset_midframe: new frame bits=%b done_at=%0d", bits, done_at);
    endtask

    initial begin
        rst     = 1'b0;
        data_in = 8'h00;
        dv0     = 1'b0;
        dv1     = 1'b0;
        dv2     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_a5();
        test_parity();
        test_back_to_back();
        test_busy();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
